// File: rtl/pipe_adder.sv
// pipe_adder: pipelined ripple-carry adder/subtractor with valid/ready back-pressure.
// Define PIPE_ADDER_OVF_EN to add the registered signed-overflow output ovf.
module pipe_adder #(
  parameter int WIDTH  = 8,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             cout
`ifdef PIPE_ADDER_OVF_EN
  ,
  output logic             ovf
`endif
);
  localparam int SEG = WIDTH / STAGES;
  logic             advance;
  logic [WIDTH-1:0] bx;
  logic             ci;
  assign advance  = !out_valid | out_ready;
  assign in_ready = advance;
  assign bx       = sub ? ~b : b;
  assign ci       = sub | cin;
  // Each stage adds its own segment and carries both operands forward for later stages.
  for (genvar i = 0; i < STAGES; i++) begin : g_st
    logic             v_q, c_q, v_d, c_d;
    logic [WIDTH-1:0] a_q, b_q, r_q, a_d, b_d, r_d, r_nx;
    logic [SEG:0]     seg;
    if (i == 0) begin : g_in
      assign v_d = in_valid;
      assign c_d = ci;
      assign a_d = a;
      assign b_d = bx;
      assign r_d = '0;
    end else begin : g_mid
      assign v_d = g_st[i-1].v_q;
      assign c_d = g_st[i-1].c_q;
      assign a_d = g_st[i-1].a_q;
      assign b_d = g_st[i-1].b_q;
      assign r_d = g_st[i-1].r_q;
    end
    assign seg = {1'b0, a_d[i*SEG +: SEG]} + {1'b0, b_d[i*SEG +: SEG]} + {{SEG{1'b0}}, c_d};
    always_comb begin
      r_nx = r_d;
      r_nx[i*SEG +: SEG] = seg[SEG-1:0];
    end
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        v_q <= 1'b0;
        c_q <= 1'b0;
        a_q <= '0;
        b_q <= '0;
        r_q <= '0;
      end else if (advance) begin
        v_q <= v_d;
        c_q <= seg[SEG];
        a_q <= a_d;
        b_q <= b_d;
        r_q <= r_nx;
      end
    end
  end
  assign out_valid = g_st[STAGES-1].v_q;
  assign s         = g_st[STAGES-1].r_q;
  assign cout      = g_st[STAGES-1].c_q;
`ifdef PIPE_ADDER_OVF_EN
  // Same-sign operands giving a different-sign MSB equals carry-in(MSB) ^ carry-out(MSB).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) ovf <= 1'b0;
    else if (advance) ovf <= (g_st[STAGES-1].a_d[WIDTH-1] == g_st[STAGES-1].b_d[WIDTH-1]) &
                             (g_st[STAGES-1].r_nx[WIDTH-1] != g_st[STAGES-1].a_d[WIDTH-1]);
  end
`endif
endmodule

// File: tb/tb_pipe_adder.sv
// tb_pipe_adder: scoreboard bench for pipe_adder (8-bit/2-stage and 4-bit/1-stage instances).
module tb_pipe_adder;
  typedef struct {logic [7:0] s; logic c; logic o;} exp_t;
  typedef struct {logic [3:0] s; logic c;} exp4_t;
  logic clk = 0, rst = 1;
  logic in_valid = 0, in_ready, cin = 0, sub = 0, out_valid, out_ready = 1, cout, ovf;
  logic [7:0] a = 0, b = 0, s;
  logic in_valid4 = 0, in_ready4, cin4 = 0, out_valid4, cout4, ovf4;
  logic [3:0] a4 = 0, b4 = 0, s4;
  exp_t  q[$];
  exp4_t q4[$];
  int n_chk = 0, n_fail = 0;

  always #5 clk = ~clk;

  pipe_adder #(.WIDTH(8), .STAGES(2)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
    .cin(cin), .sub(sub), .out_valid(out_valid), .out_ready(out_ready), .s(s), .cout(cout)
`ifdef PIPE_ADDER_OVF_EN
    , .ovf(ovf)
`endif
  );

  pipe_adder #(.WIDTH(4), .STAGES(1)) dut4 (
    .clk(clk), .rst(rst), .in_valid(in_valid4), .in_ready(in_ready4), .a(a4), .b(b4),
    .cin(cin4), .sub(1'b0), .out_valid(out_valid4), .out_ready(1'b1), .s(s4), .cout(cout4)
`ifdef PIPE_ADDER_OVF_EN
    , .ovf(ovf4)
`endif
  );

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic send(input logic [7:0] ta, input logic [7:0] tb2, input logic tc, input logic ts,
                      input logic [7:0] es, input logic ec, input logic eo);
    int n = 0;
    a = ta; b = tb2; cin = tc; sub = ts; in_valid = 1;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) chk("accept_timeout", 16'(in_ready), 16'd1);
    else q.push_back('{es, ec, eo});
    @(negedge clk);
    in_valid = 0;
  endtask

  task automatic drain();
    int n = 0;
    while ((q.size() != 0 || q4.size() != 0) && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("drain_timeout", 16'(q.size() + q4.size()), 16'd0);
  endtask

  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (q.size() == 0) chk("unexpected_out", 16'(out_valid), 16'd0);
      else begin
        exp_t e;
        e = q.pop_front();
        chk("s", 16'(s), 16'(e.s));
        chk("cout", 16'(cout), 16'(e.c));
`ifdef PIPE_ADDER_OVF_EN
        chk("ovf", 16'(ovf), 16'(e.o));
`endif
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && out_valid4) begin
      if (q4.size() == 0) chk("unexpected_out4", 16'(out_valid4), 16'd0);
      else begin
        exp4_t e;
        e = q4.pop_front();
        chk("s4_cout4", {11'd0, cout4, s4}, {11'd0, e.c, e.s});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    @(negedge clk);
    chk("rst_out_valid", 16'(out_valid), 16'd0);
    chk("rst_s", 16'(s), 16'd0);
    chk("rst_cout", 16'(cout), 16'd0);
    chk("rst_in_ready", 16'(in_ready), 16'd1);
    @(negedge clk);
    rst = 0;
    // cross-segment carry with exact 2-cycle latency
    send(8'h0F, 8'h01, 0, 0, 8'h10, 0, 0);
    chk("lat_cycle1_valid", 16'(out_valid), 16'd0);
    @(negedge clk);
    chk("lat_cycle2_valid", 16'(out_valid), 16'd1);
    chk("lat_cycle2_s", 16'(s), 16'h10);
    // back-to-back
    send(8'hFF, 8'h01, 0, 0, 8'h00, 1, 0);
    send(8'hA5, 8'h5A, 1, 0, 8'h00, 1, 0);
    // subtraction, cin ignored
    send(8'h05, 8'h07, 1, 1, 8'hFE, 0, 0);
    send(8'h07, 8'h05, 1, 1, 8'h02, 1, 0);
    // signed overflow cases
    send(8'h7F, 8'h01, 0, 0, 8'h80, 0, 1);
    send(8'h80, 8'h01, 0, 1, 8'h7F, 1, 1);
    send(8'h10, 8'h10, 0, 0, 8'h20, 0, 0);
    drain();
    // back-pressure: 3 beats against a stalled consumer
    @(posedge clk); #1 out_ready = 0;
    @(negedge clk);
    fork
      begin
        send(8'h01, 8'h02, 0, 0, 8'h03, 0, 0);
        send(8'h10, 8'h20, 0, 0, 8'h30, 0, 0);
        send(8'hFF, 8'hFF, 0, 0, 8'hFE, 1, 1'b0);
      end
      begin
        repeat (2) @(negedge clk);
        for (int k = 0; k < 5; k++) begin
          chk("bp_in_ready", 16'(in_ready), 16'd0);
          chk("bp_out_valid", 16'(out_valid), 16'd1);
          chk("bp_s_held", 16'(s), 16'h03);
          @(negedge clk);
        end
        @(posedge clk); #1 out_ready = 1;
      end
    join
    drain();
    // reset with two beats in flight
    @(posedge clk); #1 out_ready = 0;
    @(negedge clk);
    send(8'h11, 8'h22, 0, 0, 8'h33, 0, 0);
    send(8'h33, 8'h44, 0, 0, 8'h77, 0, 0);
    chk("pre_rst_valid", 16'(out_valid), 16'd1);
    rst = 1;
    #1;
    chk("async_rst_valid", 16'(out_valid), 16'd0);
    chk("async_rst_s", 16'(s), 16'd0);
    q.delete();
    @(negedge clk);
    rst = 0;
    @(posedge clk); #1 out_ready = 1;
    repeat (3) begin
      @(negedge clk);
      chk("post_rst_idle", 16'(out_valid), 16'd0);
    end
    send(8'h01, 8'h01, 0, 0, 8'h02, 0, 0);
    drain();
    // exhaustive 4-bit single-stage instance
    for (int k = 0; k < 512; k++) begin
      logic [4:0] sum;
      a4 = 4'(k); b4 = 4'(k >> 4); cin4 = k[8]; in_valid4 = 1;
      sum = {1'b0, a4} + {1'b0, b4} + {4'd0, cin4};
      q4.push_back('{sum[3:0], sum[4]});
      @(negedge clk);
    end
    in_valid4 = 0;
    drain();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
